// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I integer datapath.
// Register-file width, index width and the hardwired-zero encodings.
package rv32i_pkg;

    parameter int          RV_XLEN     = 32;
    parameter int          RV_REG_AW   = 5;
    parameter logic [4:0]  RV_X0       = 5'd0;
    parameter logic [31:0] RV_REG_ZERO = 32'h0;

    typedef logic [RV_XLEN-1:0]   rv_word_t;
    typedef logic [RV_REG_AW-1:0] rv_reg_idx_t;

endpackage : rv32i_pkg

// File: rtl/rv32i_reg_word.sv
// One architectural register.
// Clear takes priority over write; otherwise the word holds its value.
module rv32i_reg_word
    import rv32i_pkg::*;
#(
    parameter int W = RV_XLEN
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_we,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] word_q;
    logic [W-1:0] word_d;

    // Next-state selection: clear, load or hold.
    always_comb begin
        word_d = word_q;
        if (i_clr) begin
            word_d = {W{1'b0}};
        end else if (i_we) begin
            word_d = i_d;
        end else begin
            word_d = word_q;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        word_q <= word_d;
    end

    assign o_q = word_q;

endmodule : rv32i_reg_word

// File: rtl/rv32i_regfile_2r1w.sv
// RV32I integer register file: 2 combinational read ports, 1 synchronous write port.
// x0 is not stored; an optional same-cycle write-to-read forward feeds decode.
module rv32i_regfile_2r1w
    import rv32i_pkg::*;
#(
    parameter int XLEN   = RV_XLEN,
    parameter int REG_AW = RV_REG_AW,
    parameter int BYPASS = 1
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_rd_addr,
    input  logic [XLEN-1:0]   i_rd_data,
    input  logic [REG_AW-1:0] i_rs1_addr,
    input  logic [REG_AW-1:0] i_rs2_addr,
    output logic [XLEN-1:0]   o_rs1_data,
    output logic [XLEN-1:0]   o_rs2_data
);

    localparam int                NREGS  = 2 ** REG_AW;
    localparam logic [REG_AW-1:0] X0_IDX = REG_AW'(RV_X0);
    localparam logic [XLEN-1:0]   ZERO_W = XLEN'(RV_REG_ZERO);

    logic [NREGS-1:1]            we_dec_s;
    logic [NREGS-1:0][XLEN-1:0]  word_s;
    logic                        fwd_live_s;
    logic [XLEN-1:0]             rs1_s;
    logic [XLEN-1:0]             rs2_s;

    // One-hot write decode; a write to x0 selects nothing.
    always_comb begin
        we_dec_s = {(NREGS-1){1'b0}};
        if (i_we && (i_rd_addr != X0_IDX)) begin
            we_dec_s[i_rd_addr] = 1'b1;
        end else begin
            we_dec_s = {(NREGS-1){1'b0}};
        end
    end

    assign word_s[0] = ZERO_W;

    for (genvar k = 1; k < NREGS; k++) begin : g_word
        rv32i_reg_word #(
            .W (XLEN)
        ) u_word (
            .i_clk (i_clk),
            .i_clr (i_clr),
            .i_we  (we_dec_s[k]),
            .i_d   (i_rd_data),
            .o_q   (word_s[k])
        );
    end

    // A write is forwardable only when it will actually commit (clear discards it).
    always_comb begin
        if ((BYPASS != 0) && i_we && !i_clr && (i_rd_addr != X0_IDX)) begin
            fwd_live_s = 1'b1;
        end else begin
            fwd_live_s = 1'b0;
        end
    end

    // Read port 1 mux with forward.
    always_comb begin
        if (fwd_live_s && (i_rd_addr == i_rs1_addr)) begin
            rs1_s = i_rd_data;
        end else begin
            rs1_s = word_s[i_rs1_addr];
        end
    end

    // Read port 2 mux with forward.
    always_comb begin
        if (fwd_live_s && (i_rd_addr == i_rs2_addr)) begin
            rs2_s = i_rd_data;
        end else begin
            rs2_s = word_s[i_rs2_addr];
        end
    end

    assign o_rs1_data = rs1_s;
    assign o_rs2_data = rs2_s;

endmodule : rv32i_regfile_2r1w

// File: tb/tb_rv32i_regfile_2r1w.sv
// Self-checking bench: one forwarding and one non-forwarding register file share stimulus;
// expected read values are queued when addresses are driven and popped when outputs are sampled.
module tb_rv32i_regfile_2r1w;

    logic        clk;
    logic        clr;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] byp_rs1;
    logic [31:0] byp_rs2;
    logic [31:0] nb_rs1;
    logic [31:0] nb_rs2;

    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          n_vec;
    int          n_err;

    rv32i_regfile_2r1w #(.XLEN(32), .REG_AW(5), .BYPASS(1)) dut (
        .i_clk      (clk),
        .i_clr      (clr),
        .i_we       (we),
        .i_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .o_rs1_data (byp_rs1),
        .o_rs2_data (byp_rs2)
    );

    rv32i_regfile_2r1w #(.XLEN(32), .REG_AW(5), .BYPASS(0)) dut_nb (
        .i_clk      (clk),
        .i_clr      (clr),
        .i_we       (we),
        .i_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .o_rs1_data (nb_rs1),
        .o_rs2_data (nb_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; we = 1'b0; rd_addr = 5'd0; rd_data = 32'h0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        step();
        clr = 1'b0;
        for (int a = 0; a < 32; a += 9) begin
            rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
            exp_q.push_back(32'h0); exp_q.push_back(32'h0);
            #1;
            e = exp_q.pop_front(); n_vec++;
            if (byp_rs1 !== e) begin n_err++; $display("FAIL reset_rs1 a=%0d got=%h want=%h", a, byp_rs1, e); end
            e = exp_q.pop_front(); n_vec++;
            if (nb_rs2 !== e) begin n_err++; $display("FAIL reset_rs2 a=%0d got=%h want=%h", a, nb_rs2, e); end
        end
        we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
        step();
        we = 1'b0; rs1_addr = 5'd5;
        exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs1 !== e) begin n_err++; $display("FAIL reset_prewrite got=%h want=%h", byp_rs1, e); end
        // clear and a write to x7 in the same cycle: forward suppressed, write lost
        clr = 1'b1; we = 1'b1; rd_addr = 5'd7; rd_data = 32'h00001234; rs2_addr = 5'd7;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs2 !== e) begin n_err++; $display("FAIL reset_byp_suppress got=%h want=%h", byp_rs2, e); end
        step();
        clr = 1'b0; we = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs1 !== e) begin n_err++; $display("FAIL reset_x5_cleared got=%h want=%h", byp_rs1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs2 !== e) begin n_err++; $display("FAIL reset_x7_lost got=%h want=%h", byp_rs2, e); end
        e = exp_q.pop_front(); n_vec++;
        if (nb_rs1 !== e) begin n_err++; $display("FAIL reset_x5_cleared_nb got=%h want=%h", nb_rs1, e); end
    endtask

    task automatic test_x0();
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; rs1_addr = 5'd0; rs2_addr = 5'd0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs1 !== e) begin n_err++; $display("FAIL x0_same_cycle_rs1 got=%h want=%h", byp_rs1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs2 !== e) begin n_err++; $display("FAIL x0_same_cycle_rs2 got=%h want=%h", byp_rs2, e); end
        step();
        we = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs1 !== e) begin n_err++; $display("FAIL x0_after_rs1 got=%h want=%h", byp_rs1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (nb_rs2 !== e) begin n_err++; $display("FAIL x0_after_rs2_nb got=%h want=%h", nb_rs2, e); end
    endtask

    task automatic test_basic();
        we = 1'b1; rd_addr = 5'd1; rd_data = 32'h00000011;
        step();
        rd_addr = 5'd31; rd_data = 32'h80000000;
        step();
        we = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd31;
        exp_q.push_back(32'h00000011); exp_q.push_back(32'h80000000);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs1 !== e) begin n_err++; $display("FAIL basic_x1 got=%h want=%h", byp_rs1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs2 !== e) begin n_err++; $display("FAIL basic_x31 got=%h want=%h", byp_rs2, e); end
        rs1_addr = 5'd31;
        exp_q.push_back(32'h80000000); exp_q.push_back(32'h80000000);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs1 !== e) begin n_err++; $display("FAIL basic_same_rs1 got=%h want=%h", byp_rs1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs2 !== e) begin n_err++; $display("FAIL basic_same_rs2 got=%h want=%h", byp_rs2, e); end
    endtask

    task automatic test_bypass();
        we = 1'b1; rd_addr = 5'd9; rd_data = 32'hA5A5A5A5;
        step();
        rd_data = 32'h5A5A5A5A; rs1_addr = 5'd9; rs2_addr = 5'd8;
        exp_q.push_back(32'h5A5A5A5A); exp_q.push_back(32'h0); exp_q.push_back(32'hA5A5A5A5);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs1 !== e) begin n_err++; $display("FAIL bypass_fwd got=%h want=%h", byp_rs1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs2 !== e) begin n_err++; $display("FAIL bypass_other_port got=%h want=%h", byp_rs2, e); end
        e = exp_q.pop_front(); n_vec++;
        if (nb_rs1 !== e) begin n_err++; $display("FAIL nobypass_old got=%h want=%h", nb_rs1, e); end
        step();
        we = 1'b0;
        exp_q.push_back(32'h5A5A5A5A); exp_q.push_back(32'h5A5A5A5A);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (nb_rs1 !== e) begin n_err++; $display("FAIL nobypass_new got=%h want=%h", nb_rs1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (byp_rs1 !== e) begin n_err++; $display("FAIL bypass_stored got=%h want=%h", byp_rs1, e); end
    endtask

    task automatic test_write_disable();
        we = 1'b1; rd_addr = 5'd3; rd_data = 32'h00000042;
        step();
        we = 1'b0; rd_data = 32'hCAFEF00D; rs1_addr = 5'd3; rs2_addr = 5'd3;
        for (int c = 0; c < 4; c++) begin
            step();
            exp_q.push_back(32'h00000042); exp_q.push_back(32'h00000042);
            e = exp_q.pop_front(); n_vec++;
            if (byp_rs1 !== e) begin n_err++; $display("FAIL hold_x3 c=%0d got=%h want=%h", c, byp_rs1, e); end
            e = exp_q.pop_front(); n_vec++;
            if (nb_rs2 !== e) begin n_err++; $display("FAIL hold_x3_nb c=%0d got=%h want=%h", c, nb_rs2, e); end
        end
    endtask

    task automatic test_sweep();
        we = 1'b1;
        for (int k = 1; k < 32; k++) begin
            rd_addr = 5'(k); rd_data = 32'(k);
            step();
        end
        we = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rs1_addr = 5'(k); rs2_addr = 5'(31 - k);
            exp_q.push_back(32'(k)); exp_q.push_back(32'(31 - k));
            #1;
            e = exp_q.pop_front(); n_vec++;
            if (byp_rs1 !== e) begin n_err++; $display("FAIL sweep_rs1 k=%0d got=%h want=%h", k, byp_rs1, e); end
            e = exp_q.pop_front(); n_vec++;
            if (nb_rs2 !== e) begin n_err++; $display("FAIL sweep_rs2 k=%0d got=%h want=%h", k, nb_rs2, e); end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        clr = 1'b0; we = 1'b0; rd_addr = 5'd0; rd_data = 32'h0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        test_reset();
        test_x0();
        test_basic();
        test_bypass();
        test_write_disable();
        test_sweep();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rv32i_regfile_2r1w
